// File: rtl/approx_error_monitor_if.sv
// approx_error_monitor_if: sample stream (operands plus approximate product) with valid/ready handshake.
interface approx_error_monitor_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p_approx;
    modport master(output in_valid, a, b, p_approx, input in_ready);
    modport slave(input in_valid, a, b, p_approx, output in_ready);
endinterface

// File: rtl/approx_error_monitor.sv
// approx_error_monitor: accumulates error statistics of an approximate 8x8 multiplier over a run of samples.
// Define APPROX_ERR_BIAS_EN to accumulate signed bias into bias_sum; otherwise bias_sum is tied to 0.
module approx_error_monitor #(
    parameter int NUM_SAMPLES = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    approx_error_monitor_if.slave smp,
    output logic                busy,
    output logic                done,
    output logic [15:0]         err_count,
    output logic [31:0]         sum_ed,
    output logic [15:0]         max_ed,
    output logic signed [32:0]  bias_sum
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t      state;
    logic [15:0] cnt;
    logic [15:0] exact;
    logic [15:0] ed;
    logic        take;
    logic        s1_v;
    logic [15:0] s1_ed;
    logic        launch;
    assign exact  = smp.a * smp.b;
    assign ed     = smp.p_approx >= exact ? smp.p_approx - exact : exact - smp.p_approx;
    assign take   = smp.in_valid && smp.in_ready;
    assign launch = state == IDLE && start;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            smp.in_ready <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cnt          <= '0;
            s1_v         <= 1'b0;
            s1_ed        <= '0;
            err_count    <= '0;
            sum_ed       <= '0;
            max_ed       <= '0;
        end else begin
            done <= 1'b0;
            s1_v <= take;
            if (take) s1_ed <= ed;
            if (s1_v) begin
                err_count <= err_count + 16'(s1_ed != 16'd0);
                sum_ed    <= sum_ed + {16'd0, s1_ed};
                if (s1_ed > max_ed) max_ed <= s1_ed;
            end
            case (state)
                IDLE: if (start) begin
                    state        <= RUN;
                    smp.in_ready <= 1'b1;
                    busy         <= 1'b1;
                    cnt          <= '0;
                    err_count    <= '0;
                    sum_ed       <= '0;
                    max_ed       <= '0;
                end
                RUN: if (take) begin
                    cnt <= cnt + 16'd1;
                    if (cnt == 16'(NUM_SAMPLES - 1)) begin
                        state        <= DRAIN;
                        smp.in_ready <= 1'b0;
                    end
                end
                // the last sample is still in stage 1 on the first drain cycle
                DRAIN: if (!s1_v) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
`ifdef APPROX_ERR_BIAS_EN
    logic signed [16:0] s1_diff;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_diff  <= '0;
            bias_sum <= '0;
        end else begin
            if (take) s1_diff <= $signed({1'b0, smp.p_approx}) - $signed({1'b0, exact});
            if (launch) bias_sum <= '0;
            else if (s1_v) bias_sum <= bias_sum + {{16{s1_diff[16]}}, s1_diff};
        end
    end
`else
    assign bias_sum = '0;
`endif
endmodule

// File: tb/tb_approx_error_monitor.sv
// tb_approx_error_monitor: randomized run-level checks of approx_error_monitor against a per-run statistics model.
// Two instances (4 and 2 samples per run) share clock and reset.
module tb_approx_error_monitor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic              st[2];
    logic              vld[2];
    logic [7:0]        da[2];
    logic [7:0]        db[2];
    logic [15:0]       dp[2];
    logic              rdy[2];
    logic              bsy[2];
    logic              dn[2];
    logic [15:0]       ec[2];
    logic [15:0]       mx[2];
    logic [31:0]       se[2];
    logic signed [32:0] bs[2];
    approx_error_monitor_if i0();
    approx_error_monitor_if i1();
    assign i0.in_valid = vld[0];
    assign i0.a = da[0];
    assign i0.b = db[0];
    assign i0.p_approx = dp[0];
    assign rdy[0] = i0.in_ready;
    assign i1.in_valid = vld[1];
    assign i1.a = da[1];
    assign i1.b = db[1];
    assign i1.p_approx = dp[1];
    assign rdy[1] = i1.in_ready;
    approx_error_monitor #(.NUM_SAMPLES(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .smp(i0.slave), .busy(bsy[0]), .done(dn[0]),
        .err_count(ec[0]), .sum_ed(se[0]), .max_ed(mx[0]), .bias_sum(bs[0])
    );
    approx_error_monitor #(.NUM_SAMPLES(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .smp(i1.slave), .busy(bsy[1]), .done(dn[1]),
        .err_count(ec[1]), .sum_ed(se[1]), .max_ed(mx[1]), .bias_sum(bs[1])
    );
    int total = 0;
    int bad = 0;
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [15:0] qp[$];
    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask
    task automatic add(input int a, input int b, input int p);
        qa.push_back(8'(a));
        qb.push_back(8'(b));
        qp.push_back(16'(p));
    endtask
    task automatic add_rand();
        int a = $urandom_range(0, 255);
        int b = $urandom_range(0, 255);
        int p;
        case ($urandom_range(0, 2))
            0: p = a * b;
            1: p = a * b + $urandom_range(0, 40) - 20;
            default: p = $urandom_range(0, 65535);
        endcase
        p = p < 0 ? 0 : p > 65535 ? 65535 : p;
        add(a, b, p);
    endtask
    task automatic garbage(input int sel);
        da[sel] = 8'($urandom);
        db[sel] = 8'($urandom);
        dp[sel] = 16'($urandom);
    endtask
    task automatic expect_results(input int sel, input string tag);
        longint e = 0, s = 0, m = 0, bi = 0;
        foreach (qa[i]) begin
            longint d = longint'(qp[i]) - longint'(qa[i]) * longint'(qb[i]);
            longint ad = d < 0 ? -d : d;
            if (ad != 0) e++;
            s += ad;
            if (ad > m) m = ad;
            bi += d;
        end
`ifndef APPROX_ERR_BIAS_EN
        bi = 0;
`endif
        chk({tag, ".err_count"}, ec[sel], e);
        chk({tag, ".sum_ed"}, se[sel], s);
        chk({tag, ".max_ed"}, mx[sel], m);
        chk({tag, ".bias_sum"}, bs[sel], bi);
    endtask
    task automatic run(input int sel, input int n, input bit rnd, input bit poke, input string tag);
        int acc = 0;
        int cyc = 0;
        int w = 1;
        repeat (2) begin
            @(negedge clk);
            chk({tag, ".rdy_idle"}, rdy[sel], 0);
            vld[sel] = 1'b1;
            garbage(sel);
        end
        @(negedge clk);
        st[sel] = 1'b1;
        garbage(sel);
        @(negedge clk);
        st[sel] = 1'b0;
        while (acc < n && cyc < 2000) begin
            cyc++;
            chk({tag, ".rdy_run"}, rdy[sel], 1);
            chk({tag, ".busy_run"}, bsy[sel], 1);
            st[sel] = poke ? 1'($urandom) : 1'b0;
            vld[sel] = rnd ? 1'($urandom) : 1'b1;
            if (vld[sel]) begin
                da[sel] = qa[acc];
                db[sel] = qb[acc];
                dp[sel] = qp[acc];
                acc++;
            end else garbage(sel);
            @(negedge clk);
        end
        chk({tag, ".accepted"}, acc, n);
        st[sel] = 1'b0;
        while (!dn[sel] && w < 20) begin
            chk({tag, ".rdy_drain"}, rdy[sel], 0);
            chk({tag, ".busy_drain"}, bsy[sel], 1);
            vld[sel] = 1'($urandom);
            garbage(sel);
            @(negedge clk);
            w++;
        end
        chk({tag, ".done_latency"}, w, 3);
        chk({tag, ".busy_done"}, bsy[sel], 0);
        expect_results(sel, tag);
        st[sel] = poke;
        @(negedge clk);
        st[sel] = 1'b0;
        vld[sel] = 1'b0;
        chk({tag, ".done_pulse"}, dn[sel], 0);
        chk({tag, ".busy_after"}, bsy[sel], 0);
        chk({tag, ".rdy_after"}, rdy[sel], 0);
        expect_results(sel, {tag, ".held"});
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        for (int s = 0; s < 2; s++) begin
            st[s] = 1'b0;
            vld[s] = 1'b0;
            garbage(s);
        end
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("reset.busy", bsy[s], 0);
            chk("reset.done", dn[s], 0);
            chk("reset.rdy", rdy[s], 0);
            chk("reset.err_count", ec[s], 0);
            chk("reset.sum_ed", se[s], 0);
            chk("reset.max_ed", mx[s], 0);
            chk("reset.bias_sum", bs[s], 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) add(255, 255, 65025);
        run(0, 4, 0, 0, "all_exact");
        qa.delete(); qb.delete(); qp.delete();
        add(255, 255, 65000);
        add(3, 7, 21);
        add(0, 200, 0);
        add(128, 2, 256);
        run(0, 4, 0, 0, "one_err");
        qa.delete(); qb.delete(); qp.delete();
        add(240, 205, 49200);
        add(15, 15, 240);
        run(1, 2, 0, 0, "n2");
        for (int k = 0; k < 8; k++) begin
            int sel = k % 2;
            qa.delete(); qb.delete(); qp.delete();
            repeat (sel ? 2 : 4) add_rand();
            run(sel, sel ? 2 : 4, 1, k >= 4, $sformatf("rnd%0d", k));
        end
        qa.delete(); qb.delete(); qp.delete();
        add(10, 10, 90);
        add(3, 3, 20);
        @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        foreach (qa[i]) begin
            vld[0] = 1'b1;
            da[0] = qa[i];
            db[0] = qb[i];
            dp[0] = qp[i];
            @(negedge clk);
        end
        vld[0] = 1'b0;
        repeat (2) @(negedge clk);
        expect_results(0, "partial");
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.busy", bsy[0], 0);
        chk("midrst.rdy", rdy[0], 0);
        chk("midrst.err_count", ec[0], 0);
        chk("midrst.sum_ed", se[0], 0);
        chk("midrst.max_ed", mx[0], 0);
        chk("midrst.bias_sum", bs[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("postrst.done", dn[0], 0);
            chk("postrst.busy", bsy[0], 0);
        end
        qa.delete(); qb.delete(); qp.delete();
        repeat (4) add_rand();
        run(0, 4, 1, 0, "after_rst");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
